// File: rtl/uart_echo_msg_ctrl_pkg.sv
// Shared constants for the UART echo/message controller: FSM and mode
// encodings, ASCII codes and the button message ROM.
package uart_echo_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_MSG_LOAD  = 3'd1;
   localparam logic [2:0] ST_ECHO_LOAD = 3'd2;
   localparam logic [2:0] ST_SEND      = 3'd3;
   localparam logic [2:0] ST_SETTLE    = 3'd4;
   localparam logic [2:0] ST_WAIT_RDY  = 3'd5;
   localparam logic [2:0] ST_LF_LOAD   = 3'd6;

   localparam logic [1:0] MODE_MSG     = 2'd0;
   localparam logic [1:0] MODE_ECHO    = 2'd1;
   localparam logic [1:0] MODE_ECHO_LF = 2'd2;

   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] ETX = 8'h03;
   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] LF  = 8'h0A;

   localparam logic [7:0] MSG_ROM [0:15] = '{
      STX, 8'h41, 8'h52, 8'h54, 8'h59, CR, LF, ETX,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/uart_echo_msg_ctrl_if.sv
// Byte handshake between the controller and the UART RX/TX controllers.
interface uart_echo_msg_ctrl_if;
   import uart_echo_pkg::*;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic       tx_send;
   logic [7:0] tx_data;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output tx_send, tx_data
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  tx_send, tx_data
   );

endinterface

// File: rtl/uart_echo_msg_ctrl_btn_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle pulse when the
// debounced level rises.
module btn_debounce
   import uart_echo_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic btn_raw,
   output logic btn_rise
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync_1;
   logic          sync_2;
   logic          deb;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         deb      <= 1'b0;
         cnt      <= '0;
         btn_rise <= 1'b0;
      end else begin
         sync_1   <= btn_raw;
         sync_2   <= sync_1;
         btn_rise <= 1'b0;
         // count only while the input disagrees; any agreement restarts
         if (sync_2 != deb) begin
            if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
               deb      <= sync_2;
               cnt      <= '0;
               btn_rise <= sync_2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/uart_echo_msg_ctrl.sv
// Echo/message controller: buffers RX bytes in a FIFO and replays them via
// the TX controller; a debounced button press sends the ROM message.
module uart_echo_msg_ctrl
   import uart_echo_pkg::*;
#(
   parameter int MSG_LEN      = 8,
   parameter int FIFO_AW      = 4,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int CR_EXPAND    = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 btn_0,
   uart_echo_msg_ctrl_if.master bus,
   output logic [FIFO_AW:0]     fifo_count,
   output logic                 overflow,
   output logic                 busy
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [2:0]         state;
   logic [1:0]         mode;
   logic [4:0]         msg_idx;
   logic               btn_pend;
   logic               btn_rise;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               fifo_wr;
   logic               fifo_rd;
   logic               enter_msg;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .btn_raw  (btn_0),
      .btn_rise (btn_rise)
   );

   assign fifo_wr     = bus.rx_valid && (fifo_count < (FIFO_AW+1)'(DEPTH));
   assign fifo_rd     = (state == ST_ECHO_LOAD);
   assign enter_msg   = (state == ST_IDLE) && btn_pend;
   assign bus.tx_send = (state == ST_SEND);
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge CLK) begin
      if (fifo_wr) mem[wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (bus.rx_valid && !fifo_wr) overflow <= 1'b1;
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // clearing on MSG_LOAD entry wins, so a press landing in that cycle is dropped
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)         btn_pend <= 1'b0;
      else if (enter_msg) btn_pend <= 1'b0;
      else if (btn_rise)  btn_pend <= 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         mode        <= MODE_MSG;
         msg_idx     <= '0;
         bus.tx_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (btn_pend) begin
                  msg_idx <= '0;
                  state   <= ST_MSG_LOAD;
               end else if (fifo_count != '0) begin
                  state <= ST_ECHO_LOAD;
               end
            end
            ST_MSG_LOAD: begin
               bus.tx_data <= MSG_ROM[msg_idx[3:0]];
               msg_idx     <= msg_idx + 5'd1;
               mode        <= MODE_MSG;
               state       <= ST_SEND;
            end
            ST_ECHO_LOAD: begin
               bus.tx_data <= mem[rd_ptr];
               mode        <= MODE_ECHO;
               state       <= ST_SEND;
            end
            ST_LF_LOAD: begin
               bus.tx_data <= LF;
               mode        <= MODE_ECHO_LF;
               state       <= ST_SEND;
            end
            ST_SEND:   state <= ST_SETTLE;
            ST_SETTLE: state <= ST_WAIT_RDY;
            ST_WAIT_RDY: begin
               if (bus.tx_ready) begin
                  if (mode == MODE_MSG && msg_idx < 5'(MSG_LEN))
                     state <= ST_MSG_LOAD;
                  else if (mode == MODE_ECHO && CR_EXPAND != 0 && bus.tx_data == CR)
                     state <= ST_LF_LOAD;
                  else
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_echo_msg_ctrl.sv
// Directed bench for uart_echo_msg_ctrl with a simple TX controller model.
module tb_uart_echo_msg_ctrl;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic btn_0 = 1'b0;
   always #5 CLK = ~CLK;

   uart_echo_msg_ctrl_if bus ();
   uart_echo_msg_ctrl_if bus0 ();

   logic [4:0] fifo_count, fifo_count0;
   logic       overflow, overflow0, busy, busy0;

   uart_echo_msg_ctrl #(.DEBOUNCE_CYC(16)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .btn_0      (btn_0),
      .bus        (bus),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .busy       (busy)
   );

   uart_echo_msg_ctrl #(.DEBOUNCE_CYC(16), .CR_EXPAND(0)) dut0 (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .btn_0      (1'b0),
      .bus        (bus0),
      .fifo_count (fifo_count0),
      .overflow   (overflow0),
      .busy       (busy0)
   );

   logic [7:0] MSG [8] = '{8'h02, 8'h41, 8'h52, 8'h54, 8'h59, 8'h0D, 8'h0A, 8'h03};

   int         total = 0;
   int         bad   = 0;
   int         peak  = 0;
   int         tcnt  = 0;
   int         tx_delay = 100;
   bit         hold  = 1'b0;
   logic [7:0] cap  [$];
   logic [7:0] cap0 [$];

   // TX controller model: drops ready after each send for tx_delay cycles
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.tx_ready <= 1'b1;
         tcnt         <= 0;
      end else if (bus.tx_send) begin
         cap.push_back(bus.tx_data);
         bus.tx_ready <= 1'b0;
         tcnt         <= tx_delay;
      end else if (hold) begin
         bus.tx_ready <= 1'b0;
      end else if (tcnt > 0) begin
         tcnt <= tcnt - 1;
      end else begin
         bus.tx_ready <= 1'b1;
      end
   end

   assign bus0.tx_ready = 1'b1;
   always @(posedge CLK) if (RST_N && bus0.tx_send) cap0.push_back(bus0.tx_data);

   always @(negedge CLK) if (int'(fifo_count) > peak) peak = int'(fifo_count);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge CLK);
      bus.rx_valid = 1'b0;
   endtask

   task automatic press(input int n);
      btn_0 = 1'b1;
      cyc(n);
      btn_0 = 1'b0;
   endtask

   task automatic wait_cap(input int n, input string tag);
      int k = 0;
      while (cap.size() < n && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, cap.size(), n);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy || fifo_count != 0) && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, {busy, fifo_count}, 0);
   endtask

   task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
      logic [31:0] got;
      got = (idx < cap.size()) ? 32'(cap[idx]) : 32'hFFFF;
      chk($sformatf("%s[%0d]", tag, idx), got, 32'(exp));
   endtask

   initial begin
      bus.rx_data   = '0;
      bus.rx_valid  = 1'b0;
      bus0.rx_data  = '0;
      bus0.rx_valid = 1'b0;

      // reset values
      cyc(3);
      chk("rst_tx_send", bus.tx_send, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      RST_N = 1'b1;
      cyc(10000);
      chk("idle_sends", cap.size(), 0);
      chk("idle_busy", busy, 0);
      chk("idle_count", fifo_count, 0);

      // button message
      press(20);
      wait_cap(8, "msg_tmo");
      for (int i = 0; i < 8; i++) chk_byte("msg", i, MSG[i]);
      wait_idle("msg_idle");
      cyc(200);
      chk("msg_total", cap.size(), 8);

      // bytes arriving during a message accumulate and echo afterwards
      cap.delete();
      press(20);
      wait_cap(1, "acc_start");
      peak = 0;
      rx_byte(8'h54);
      rx_byte(8'h33);
      rx_byte(8'h35);
      cyc(1);
      chk("acc_peak", peak, 3);
      chk("acc_count", fifo_count, 3);
      wait_cap(11, "acc_tmo");
      for (int i = 0; i < 8; i++) chk_byte("acc_msg", i, MSG[i]);
      chk_byte("acc_echo", 8, 8'h54);
      chk_byte("acc_echo", 9, 8'h33);
      chk_byte("acc_echo", 10, 8'h35);
      wait_idle("acc_idle");
      chk("acc_total", cap.size(), 11);

      // CR expansion on and off
      cap.delete();
      rx_byte(8'h0D);
      wait_cap(2, "cr_tmo");
      chk_byte("cr", 0, 8'h0D);
      chk_byte("cr", 1, 8'h0A);
      wait_idle("cr_idle");
      cyc(50);
      chk("cr_total", cap.size(), 2);
      bus0.rx_data  = 8'h0D;
      bus0.rx_valid = 1'b1;
      @(negedge CLK);
      bus0.rx_valid = 1'b0;
      cyc(50);
      chk("nocr_total", cap0.size(), 1);
      chk("nocr_byte", (cap0.size() > 0) ? 32'(cap0[0]) : 32'hFFFF, 32'h0D);
      chk("nocr_busy", busy0, 0);

      // overflow: FSM stuck in WAIT_RDY on a primer byte, then 17 bytes
      cap.delete();
      hold = 1'b1;
      rx_byte(8'h50);
      cyc(10);
      for (int i = 0; i < 17; i++) rx_byte(8'(8'h60 + i));
      cyc(1);
      chk("ovf_count", fifo_count, 16);
      chk("ovf_flag", overflow, 1);
      hold = 1'b0;
      wait_cap(17, "ovf_tmo");
      chk_byte("ovf", 0, 8'h50);
      for (int i = 1; i < 17; i++) chk_byte("ovf", i, 8'(8'h60 + i - 1));
      wait_idle("ovf_idle");
      cyc(200);
      chk("ovf_total", cap.size(), 17);

      // one message despite a bounce; echo after it; press during echo served later
      cap.delete();
      press(20);
      wait_cap(1, "bnc_start");
      cyc(40);
      press(5);
      wait_cap(3, "bnc_third");
      rx_byte(8'h41);
      wait_cap(9, "bnc_tmo");
      for (int i = 0; i < 8; i++) chk_byte("bnc_msg", i, MSG[i]);
      chk_byte("bnc_echo", 8, 8'h41);
      press(20);
      wait_cap(17, "bnc2_tmo");
      for (int i = 0; i < 8; i++) chk_byte("bnc_msg2", 9 + i, MSG[i]);
      wait_idle("bnc_idle");
      cyc(300);
      chk("bnc_total", cap.size(), 17);

      // asynchronous reset while waiting for TX ready
      hold = 1'b1;
      rx_byte(8'h55);
      cyc(10);
      rx_byte(8'h56);
      rx_byte(8'h57);
      cyc(2);
      chk("ar_pre_busy", busy, 1);
      chk("ar_pre_count", fifo_count, 2);
      #2 RST_N = 1'b0;
      #1;
      chk("ar_tx_send", bus.tx_send, 0);
      chk("ar_fifo_count", fifo_count, 0);
      chk("ar_busy", busy, 0);
      chk("ar_overflow", overflow, 0);
      chk("ar_tx_data", bus.tx_data, 0);
      hold = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
